btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner.sv | 98 +++++++++
 tb/tb_btn_conditioner.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Synchronizes, debounces and conflict-resolves three board buttons for player_move.
// Latency: raw edge sampled at edge 1 -> db at edge DB_CYCLES+2 -> outputs at DB_CYCLES+3; no backpressure.
module btn_conditioner #(
    parameter int DB_CYCLES = 250000,
    parameter int CNT_W     = 18
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_left_raw,
    input  logic btn_right_raw,
    input  logic btn_jump_raw,
    output logic move_left,
    output logic move_right,
    output logic jump,
    output logic jump_held
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    // Bit 0 = left, bit 1 = right, bit 2 = jump throughout.
    logic [2:0]       raw;
    logic [2:0]       s0;
    logic [2:0]       s1;
    logic [2:0]       db;
    logic [2:0]       db_d;
    logic [CNT_W-1:0] cnt [3];
    logic             last_dir;

    logic [2:0] rise;
    logic       dir_nxt;
    logic       left_nxt;
    logic       right_nxt;

    assign raw = {btn_jump_raw, btn_right_raw, btn_left_raw};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0 <= '0;
            s1 <= '0;
        end else begin
            s0 <= raw;
            s1 <= s0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (s1[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    db[i]  <= s1[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // The direction used for this update already includes any rise seen now,
    // so a fresh press wins on the same output edge it first appears.
    always_comb begin
        rise      = db & ~db_d;
        dir_nxt   = last_dir;
        if (rise[0]) begin
            dir_nxt = 1'b0;
        end else if (rise[1]) begin
            dir_nxt = 1'b1;
        end
        left_nxt  = db[0] & (~db[1] | ~dir_nxt);
        right_nxt = db[1] & (~db[0] |  dir_nxt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_d       <= '0;
            last_dir   <= 1'b0;
            move_left  <= 1'b0;
            move_right <= 1'b0;
            jump       <= 1'b0;
            jump_held  <= 1'b0;
        end else begin
            db_d       <= db;
            last_dir   <= dir_nxt;
            move_left  <= left_nxt;
            move_right <= right_nxt;
            jump       <= rise[2];
            jump_held  <= db[2];
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboarded directed test of btn_conditioner with DB_CYCLES = 4.
module tb_btn_conditioner;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_left_raw = 1'b0;
    logic btn_right_raw = 1'b0;
    logic btn_jump_raw = 1'b0;
    logic move_left;
    logic move_right;
    logic jump;
    logic jump_held;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] exp_q[$];

    btn_conditioner #(.DB_CYCLES(4), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_left_raw (btn_left_raw),
        .btn_right_raw(btn_right_raw),
        .btn_jump_raw (btn_jump_raw),
        .move_left    (move_left),
        .move_right   (move_right),
        .jump         (jump),
        .jump_held    (jump_held)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got {ml,mr,jp,jh}=%b expected %b", name, $time, act, req);
        end
    endtask

    // Drive one cycle's inputs and queue the outputs expected after the next rising edge.
    task automatic cyc(input logic rst, input logic l, input logic r, input logic j,
                       input logic [3:0] exp_out);
        @(negedge clk);
        reset         = rst;
        btn_left_raw  = l;
        btn_right_raw = r;
        btn_jump_raw  = j;
        exp_q.push_back(exp_out);
    endtask

    task automatic rep(input int n, input logic rst, input logic l, input logic r, input logic j,
                       input logic [3:0] exp_out);
        for (int k = 0; k < n; k++) begin
            cyc(rst, l, r, j, exp_out);
        end
    endtask

    initial begin : monitor
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs", {move_left, move_right, jump, jump_held}, e);
                n_cmp++;
                if (move_left && move_right) begin
                    n_bad++;
                    $display("FAIL exclusive_dir at %0t: move_left=%b move_right=%b, required not both 1",
                             $time, move_left, move_right);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // reset state
        rep(3, 1, 0, 0, 0, 4'b0000);
        rep(2, 0, 0, 0, 0, 4'b0000);

        // left press: output rises exactly at edge 7, then release
        rep(6, 0, 1, 0, 0, 4'b0000);
        rep(3, 0, 1, 0, 0, 4'b1000);
        rep(6, 0, 0, 0, 0, 4'b1000);
        rep(3, 0, 0, 0, 0, 4'b0000);

        // 3-cycle jump glitch is rejected
        rep(3, 0, 0, 0, 1, 4'b0000);
        rep(8, 0, 0, 0, 0, 4'b0000);

        // jump held 20 cycles: one pulse, held level until release
        rep(6,  0, 0, 0, 1, 4'b0000);
        rep(1,  0, 0, 0, 1, 4'b0011);
        rep(13, 0, 0, 0, 1, 4'b0001);
        rep(6,  0, 0, 0, 0, 4'b0001);
        rep(3,  0, 0, 0, 0, 4'b0000);

        // left held, right pressed (right wins), right released (back to left)
        rep(6, 0, 1, 0, 0, 4'b0000);
        rep(4, 0, 1, 0, 0, 4'b1000);
        rep(6, 0, 1, 1, 0, 4'b1000);
        rep(4, 0, 1, 1, 0, 4'b0100);
        rep(6, 0, 1, 0, 0, 4'b0100);
        rep(4, 0, 1, 0, 0, 4'b1000);
        rep(6, 0, 0, 0, 0, 4'b1000);
        rep(3, 0, 0, 0, 0, 4'b0000);

        // simultaneous left+right rise: left wins even though right won last
        rep(6, 0, 1, 1, 0, 4'b0000);
        rep(4, 0, 1, 1, 0, 4'b1000);
        rep(6, 0, 0, 0, 0, 4'b1000);
        rep(3, 0, 0, 0, 0, 4'b0000);

        // right+jump held, then left starts debouncing and reset hits mid-count
        rep(6, 0, 0, 1, 1, 4'b0000);
        rep(1, 0, 0, 1, 1, 4'b0111);
        rep(2, 0, 0, 1, 1, 4'b0101);
        rep(2, 0, 1, 1, 1, 4'b0101);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", {move_left, move_right, jump, jump_held}, 4'b0000);
        rep(2, 1, 1, 1, 1, 4'b0000);
        // after release everything re-debounces from zero; jump pulses once
        rep(6, 0, 1, 1, 1, 4'b0000);
        rep(1, 0, 1, 1, 1, 4'b1011);
        rep(2, 0, 1, 1, 1, 4'b1001);

        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
